// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests to an
// in-order instruction memory, buffers returned words and hands them to decode.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  input  logic        inst_ready,
  output logic        err_resp
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] fifo_rd;
  logic [PW-1:0] fifo_wr;
  logic [PW-1:0] pend_rd;
  logic [PW-1:0] pend_wr;
  logic          err_q;

  logic [31:0] fifo_data [FIFO_DEPTH];
  logic [31:0] fifo_pc   [FIFO_DEPTH];
  logic [31:0] pend_pc   [FIFO_DEPTH];

  logic [CW:0]   credit_used;
  logic [CW-1:0] outstanding_nx;
  logic          accept;
  logic          resp_ok;
  logic          push;
  logic          pop;

  // Both handshakes transfer on the rising edge where valid && ready; valid never
  // depends combinationally on the matching ready, so either side may wait on the other.
  assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response only counts when something is outstanding; anything else is flagged.
  assign resp_ok        = imem_resp_valid && (outstanding != '0);
  assign push           = resp_ok && (discard == '0) && !redirect_valid;
  assign pop            = inst_valid && inst_ready;
  assign outstanding_nx = outstanding + CW'(accept) - CW'(resp_ok);

  assign inst_valid = (fifo_count != '0);
  assign inst_data  = inst_valid ? fifo_data[fifo_rd] : 32'h0;
  assign inst_pc    = inst_valid ? fifo_pc[fifo_rd] : 32'h0;
  assign inst_pc4   = inst_pc + 32'd4;
  assign err_resp   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      pend_rd     <= '0;
      pend_wr     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (redirect_valid)
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (accept)
        fetch_pc <= fetch_pc + 32'd4;

      outstanding <= outstanding_nx;

      // Every request still in flight after a redirect belongs to the old path.
      if (redirect_valid)
        discard <= outstanding_nx;
      else if (resp_ok && (discard != '0))
        discard <= discard - 1'b1;

      if (accept)
        pend_wr <= pend_wr + 1'b1;
      if (resp_ok)
        pend_rd <= pend_rd + 1'b1;

      if (redirect_valid) begin
        fifo_rd    <= '0;
        fifo_wr    <= '0;
        fifo_count <= '0;
      end else begin
        if (push)
          fifo_wr <= fifo_wr + 1'b1;
        if (pop)
          fifo_rd <= fifo_rd + 1'b1;
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end

      if (imem_resp_valid && (outstanding == '0))
        err_q <= 1'b1;
    end
  end

  // Storage arrays carry no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && accept)
      pend_pc[pend_wr] <= fetch_pc;
    if (!rst && push) begin
      fifo_data[fifo_wr] <= imem_resp_data;
      fifo_pc[fifo_wr]   <= pend_pc[pend_rd];
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomized bench for mips_fetch_unit against an instruction-stream reference model.
module tb_mips_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic        inst_ready;
  logic        err_resp;

  mips_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_pc4(inst_pc4), .inst_ready(inst_ready), .err_resp(err_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Memory model: in-order queue of accepted addresses, each with a due cycle and a
  // flag saying whether decode should ever see it (cleared by a redirect).
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  bit          mq_live[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  int          buffered;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_pop = 0;
  int          n_triple = 0;
  int          first_acc = -1;
  int          first_val = -1;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    mq_addr.delete(); mq_due.delete(); mq_live.delete(); buffered = 0;
    @(negedge clk); #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_inst_pc4", inst_pc4, 32'd4);
    check("rst_err", {31'b0, err_resp}, 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    exp_pc = RESET_PC; exp_req = RESET_PC; first_acc = -1; first_val = -1;
  endtask

  task automatic step(input bit rdy, input bit rreq, input bit redir, input logic [31:0] tgt,
                      input int lat, input bit redir_triple, input bit inject);
    bit hs;
    bit acc;
    bit resp_live;
    int occ;
    @(negedge clk);
    cyc++;
    occ = mq_addr.size() + buffered;
    resp_live = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (inject) begin
      imem_resp_valid = 1'b1;
    end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq_addr.pop_front());
      void'(mq_due.pop_front());
      resp_live = mq_live.pop_front();
    end
    inst_ready = rdy; imem_req_ready = rreq; redirect_valid = redir; redirect_pc = tgt;
    #1;
    check("req_valid", {31'b0, imem_req_valid}, {31'b0, occ < DEPTH});
    check("inst_valid", {31'b0, inst_valid}, {31'b0, buffered != 0});
    hs  = inst_valid && inst_ready;
    acc = imem_req_valid && imem_req_ready;
    if (redir_triple && hs && acc && imem_resp_valid && !redirect_valid) begin
      redirect_valid = 1'b1;
      n_triple++;
    end
    if (first_val < 0 && inst_valid) first_val = cyc;
    if (hs) begin
      check("inst_pc", inst_pc, exp_pc);
      check("inst_data", inst_data, mem_word(exp_pc));
      check("inst_pc4", inst_pc4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      n_pop++;
      buffered--;
    end
    if (imem_resp_valid && resp_live && !redirect_valid) buffered++;
    if (acc) begin
      check("req_addr", imem_req_addr, exp_req);
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + lat);
      mq_live.push_back(1'b1);
      exp_req = exp_req + 32'd4;
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (redirect_valid) begin
      foreach (mq_live[i]) mq_live[i] = 1'b0;
      buffered = 0;
      exp_pc  = {redirect_pc[31:2], 2'b00};
      exp_req = {redirect_pc[31:2], 2'b00};
    end
  endtask

  initial begin
    int acc0;
    int pops0;
    // Latency 1, decode always ready; stream wraps 0xFFFFFFF8 -> 0xFFFFFFFC -> 0x0.
    do_reset();
    for (int i = 0; i < 12; i++) step(1, 1, 0, '0, 1, 0, 0);
    check("first_latency", first_val - first_acc, 32'd2);

    // Decode stalled: credit caps requests at DEPTH.
    do_reset();
    acc0 = n_acc;
    for (int i = 0; i < 20; i++) step(0, 1, 0, '0, 1, 0, 0);
    check("stall_requests", n_acc - acc0, DEPTH);
    // Unsolicited response with nothing outstanding.
    step(0, 1, 0, '0, 1, 0, 1);
    step(0, 1, 0, '0, 1, 0, 0);
    check("err_set", {31'b0, err_resp}, 32'd1);
    check("err_head_pc", inst_pc, exp_pc);
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0, 1, 0, 0);
    check("err_sticky", {31'b0, err_resp}, 32'd1);
    pops0 = n_pop;
    for (int i = 0; i < 20; i++) step(1, 1, 0, '0, 1, 0, 0);
    check("drain_pops", {31'b0, n_pop - pops0 >= 10}, 32'd1);

    // Latency 3 with requests in flight, then redirects to 0x40 and 0x43.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 1, 0, '0, 3, 0, 0);
    step(1, 1, 1, 32'h40, 3, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 0, '0, 3, 0, 0);
    step(1, 1, 1, 32'h43, 3, 0, 0);
    step(1, 1, 0, '0, 3, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 0, '0, 3, 0, 0);
    check("err_clean", {31'b0, err_resp}, 32'd0);

    // Random traffic, redirects (including on a response+handshake+accept cycle).
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      if (i == 1500) do_reset();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, $urandom_range(0, 99) < 3, tgt,
           $urandom_range(1, 4), $urandom_range(0, 3) == 0, 0);
    end
    check("triple_seen", {31'b0, n_triple > 0}, 32'd1);
    check("rand_pops", {31'b0, n_pop > 500}, 32'd1);
    check("rand_err", {31'b0, err_resp}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
